// File: rtl/coin_pkg.sv
// rtl/coin_pkg.sv - shared types and constants for the coin credit controller
package coin_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      VEND   = 2'd1,
      CHANGE = 2'd2
   } state_t;

   localparam int COIN100_VAL = 1;
   localparam int COIN500_VAL = 5;

   // Active-low segments ordered {g,f,e,d,c,b,a}
   localparam logic [6:0] SEG_BLANK = 7'b1111111;
   localparam logic [6:0] SEG_0     = 7'b1000000;
   localparam logic [6:0] SEG_1     = 7'b1111001;
   localparam logic [6:0] SEG_2     = 7'b0100100;
   localparam logic [6:0] SEG_3     = 7'b0110000;
   localparam logic [6:0] SEG_4     = 7'b0011001;
   localparam logic [6:0] SEG_5     = 7'b0010010;
   localparam logic [6:0] SEG_6     = 7'b0000010;
   localparam logic [6:0] SEG_7     = 7'b1111000;
   localparam logic [6:0] SEG_8     = 7'b0000000;
   localparam logic [6:0] SEG_9     = 7'b0010000;

endpackage

// File: rtl/coin_credit_ctrl_if.sv
// rtl/coin_credit_ctrl_if.sv - coin/vend inputs and dispenser/display outputs
interface coin_credit_ctrl_if #(
   parameter int CREDIT_W = 7
);
   logic                coin100;
   logic                coin500;
   logic                vend_req;
   logic                cancel;
   logic [CREDIT_W-1:0] credit;
   logic                busy;
   logic                coin_reject;
   logic                vend_o;
   logic                deny_o;
   logic                change100;
   logic                change500;
   logic [6:0]          seg_tens;
   logic [6:0]          seg_ones;

   modport master (
      output coin100, coin500, vend_req, cancel,
      input  credit, busy, coin_reject, vend_o, deny_o, change100, change500, seg_tens, seg_ones
   );

   modport slave (
      input  coin100, coin500, vend_req, cancel,
      output credit, busy, coin_reject, vend_o, deny_o, change100, change500, seg_tens, seg_ones
   );
endinterface

// File: rtl/coin_credit_ctrl_seg7_dec.sv
// rtl/coin_credit_ctrl_seg7_dec.sv - decimal digit to active-low 7-segment decoder
module seg7_dec
   import coin_pkg::*;
(
   input  logic [3:0] digit_i,
   output logic [6:0] seg_o
);

   always_comb begin
      seg_o = SEG_BLANK;
      case (digit_i)
         4'd0:    seg_o = SEG_0;
         4'd1:    seg_o = SEG_1;
         4'd2:    seg_o = SEG_2;
         4'd3:    seg_o = SEG_3;
         4'd4:    seg_o = SEG_4;
         4'd5:    seg_o = SEG_5;
         4'd6:    seg_o = SEG_6;
         4'd7:    seg_o = SEG_7;
         4'd8:    seg_o = SEG_8;
         4'd9:    seg_o = SEG_9;
         default: seg_o = SEG_BLANK;
      endcase
   end

endmodule

// File: rtl/coin_credit_ctrl.sv
// rtl/coin_credit_ctrl.sv - saturating coin credit, vend/refund FSM and 2-digit display
// Optional greedy 500-unit change is enabled by defining CHANGE_500_EN.
module coin_credit_ctrl
   import coin_pkg::*;
#(
   parameter int CREDIT_W   = 7,
   parameter int MAX_CREDIT = 15,
   parameter int PRICE      = 10
)(
   input  logic               clk,
   input  logic               rst_n,
   coin_credit_ctrl_if.slave  bus
);

   localparam logic [CREDIT_W:0]   MAX_X   = (CREDIT_W+1)'(MAX_CREDIT);
   localparam logic [CREDIT_W:0]   PRICE_X = (CREDIT_W+1)'(PRICE);
   localparam logic [CREDIT_W:0]   C100_X  = (CREDIT_W+1)'(COIN100_VAL);
   localparam logic [CREDIT_W:0]   C500_X  = (CREDIT_W+1)'(COIN500_VAL);
   localparam logic [CREDIT_W-1:0] PRICE_N = CREDIT_W'(PRICE);
   localparam logic [CREDIT_W-1:0] C100_N  = CREDIT_W'(COIN100_VAL);

   // Input bit order: {cancel, vend_req, coin500, coin100}
   logic [3:0]          in_q, prev_q, edg;
   logic                arm_q;
   state_t              state_q, state_d;
   logic [CREDIT_W-1:0] credit_q, credit_d;
   logic [CREDIT_W:0]   cr_sum;
   logic                busy_q;
   logic                reject_q, reject_d;
   logic                vend_q, vend_d;
   logic                deny_q, deny_d;
   logic                c100_q, c100_d;
   logic [3:0]          tens_dig, ones_dig;
   logic [6:0]          seg_tens_d, seg_ones_d, seg_tens_q, seg_ones_q;

   // On the first clock after reset prev is loaded from the raw pins so a level held through reset is not an edge
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         in_q   <= '0;
         prev_q <= '0;
         arm_q  <= 1'b0;
      end else begin
         arm_q  <= 1'b1;
         in_q   <= {bus.cancel, bus.vend_req, bus.coin500, bus.coin100};
         prev_q <= arm_q ? in_q : {bus.cancel, bus.vend_req, bus.coin500, bus.coin100};
      end
   end

   assign edg = in_q & ~prev_q;

`ifdef CHANGE_500_EN
   localparam logic [CREDIT_W-1:0] C500_N = CREDIT_W'(COIN500_VAL);
   logic c500_q, c500_d;
`endif

   always_comb begin
      state_d  = state_q;
      credit_d = credit_q;
      cr_sum   = {1'b0, credit_q};
      reject_d = 1'b0;
      vend_d   = 1'b0;
      deny_d   = 1'b0;
      c100_d   = 1'b0;
`ifdef CHANGE_500_EN
      c500_d   = 1'b0;
`endif
      case (state_q)
         IDLE: begin
            if (edg[3] && credit_q != '0) begin
               state_d  = CHANGE;
               reject_d = edg[1] | edg[0];
            end else begin
               if (edg[1]) begin
                  if (cr_sum + C500_X <= MAX_X) cr_sum = cr_sum + C500_X;
                  else                          reject_d = 1'b1;
               end
               if (edg[0]) begin
                  if (edg[1])                        reject_d = 1'b1;
                  else if (cr_sum + C100_X <= MAX_X) cr_sum = cr_sum + C100_X;
                  else                               reject_d = 1'b1;
               end
               credit_d = CREDIT_W'(cr_sum);
               if (edg[2]) begin
                  if (cr_sum >= PRICE_X) state_d = VEND;
                  else                   deny_d  = 1'b1;
               end
            end
         end
         VEND: begin
            reject_d = edg[1] | edg[0];
            vend_d   = 1'b1;
            credit_d = credit_q - PRICE_N;
            state_d  = (credit_d != '0) ? CHANGE : IDLE;
         end
         CHANGE: begin
            reject_d = edg[1] | edg[0];
`ifdef CHANGE_500_EN
            if (credit_q >= C500_N) begin
               c500_d   = 1'b1;
               credit_d = credit_q - C500_N;
            end else begin
               c100_d   = 1'b1;
               credit_d = credit_q - C100_N;
            end
`else
            c100_d   = 1'b1;
            credit_d = credit_q - C100_N;
`endif
            if (credit_d == '0) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         credit_q   <= '0;
         busy_q     <= 1'b0;
         reject_q   <= 1'b0;
         vend_q     <= 1'b0;
         deny_q     <= 1'b0;
         c100_q     <= 1'b0;
         seg_tens_q <= SEG_0;
         seg_ones_q <= SEG_0;
      end else begin
         state_q    <= state_d;
         credit_q   <= credit_d;
         busy_q     <= (state_d != IDLE);
         reject_q   <= reject_d;
         vend_q     <= vend_d;
         deny_q     <= deny_d;
         c100_q     <= c100_d;
         seg_tens_q <= seg_tens_d;
         seg_ones_q <= seg_ones_d;
      end
   end

`ifdef CHANGE_500_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) c500_q <= 1'b0;
      else        c500_q <= c500_d;
   end
   assign bus.change500 = c500_q;
`else
   assign bus.change500 = 1'b0;
`endif

   assign tens_dig = 4'(credit_q / CREDIT_W'(10));
   assign ones_dig = 4'(credit_q % CREDIT_W'(10));

   seg7_dec u_seg_tens (.digit_i(tens_dig), .seg_o(seg_tens_d));
   seg7_dec u_seg_ones (.digit_i(ones_dig), .seg_o(seg_ones_d));

   assign bus.credit      = credit_q;
   assign bus.busy        = busy_q;
   assign bus.coin_reject = reject_q;
   assign bus.vend_o      = vend_q;
   assign bus.deny_o      = deny_q;
   assign bus.change100   = c100_q;
   assign bus.seg_tens    = seg_tens_q;
   assign bus.seg_ones    = seg_ones_q;

endmodule

// File: tb/tb_coin_credit_ctrl.sv
// tb/tb_coin_credit_ctrl.sv - vector table, corner sequences and random model check for coin_credit_ctrl
module tb_coin_credit_ctrl;

   localparam int CW    = 7;
   localparam int MAXC  = 15;
   localparam int PRICE = 10;
`ifdef CHANGE_500_EN
   localparam bit GREEDY = 1'b1;
`else
   localparam bit GREEDY = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   coin_credit_ctrl_if #(.CREDIT_W(CW)) bus ();

   coin_credit_ctrl #(.CREDIT_W(CW), .MAX_CREDIT(MAXC), .PRICE(PRICE)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int n_cmp = 0;
   int n_fail = 0;
   int cnt_rej = 0, cnt_vend = 0, cnt_deny = 0, cnt_c100 = 0, cnt_c500 = 0;
   int s_rej, s_vend, s_deny, s_c100, s_c500;

   always @(posedge clk) begin
      #1;
      if (bus.coin_reject) cnt_rej++;
      if (bus.vend_o)      cnt_vend++;
      if (bus.deny_o)      cnt_deny++;
      if (bus.change100)   cnt_c100++;
      if (bus.change500)   cnt_c500++;
   end

   typedef struct {
      logic [3:0] act;   // {cancel, vend_req, coin500, coin100}
      int credit;
      int rej;
      int vnd;
      int dny;
      int c1;
      int c5;
   } vec_t;

   vec_t vt[17];

   function automatic logic [6:0] seg_of(input int d);
      case (d)
         0: return 7'b1000000;
         1: return 7'b1111001;
         2: return 7'b0100100;
         3: return 7'b0110000;
         4: return 7'b0011001;
         5: return 7'b0010010;
         6: return 7'b0000010;
         7: return 7'b1111000;
         8: return 7'b0000000;
         9: return 7'b0010000;
         default: return 7'b1111111;
      endcase
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic snap();
      s_rej = cnt_rej; s_vend = cnt_vend; s_deny = cnt_deny; s_c100 = cnt_c100; s_c500 = cnt_c500;
   endtask

   task automatic drive(input logic [3:0] m);
      bus.coin100  = m[0];
      bus.coin500  = m[1];
      bus.vend_req = m[2];
      bus.cancel   = m[3];
   endtask

   task automatic settle();
      int k = 0;
      repeat (3) @(negedge clk);
      while (bus.busy && k < 60) begin
         @(negedge clk);
         k++;
      end
      chk("busy_settled", int'(bus.busy), 0);
      repeat (2) @(negedge clk);
   endtask

   task automatic do_action(input logic [3:0] m, input int hold);
      @(negedge clk);
      drive(m);
      repeat (hold) @(negedge clk);
      drive(4'b0000);
      settle();
   endtask

   task automatic check_state(input string tag, input int credit, input int rej, input int vnd,
                              input int dny, input int c1, input int c5);
      chk({tag, "_credit"}, int'(bus.credit), credit);
      chk({tag, "_reject"}, cnt_rej - s_rej, rej);
      chk({tag, "_vend"},   cnt_vend - s_vend, vnd);
      chk({tag, "_deny"},   cnt_deny - s_deny, dny);
      chk({tag, "_c100"},   cnt_c100 - s_c100, c1);
      chk({tag, "_c500"},   cnt_c500 - s_c500, c5);
      chk({tag, "_segt"},   int'(bus.seg_tens), int'(seg_of(credit / 10)));
      chk({tag, "_sego"},   int'(bus.seg_ones), int'(seg_of(credit % 10)));
   endtask

   // Reference model: whole-transaction effect of one action on credit and pulse counts
   int m_credit;
   int e_rej, e_vnd, e_dny, e_c1, e_c5;

   task automatic model_refund(input int amt);
      if (GREEDY) begin
         e_c5 = amt / 5;
         e_c1 = amt % 5;
      end else begin
         e_c1 = amt;
      end
      m_credit = 0;
   endtask

   task automatic model_apply(input int kind);
      e_rej = 0; e_vnd = 0; e_dny = 0; e_c1 = 0; e_c5 = 0;
      case (kind)
         0: if (m_credit + 1 <= MAXC) m_credit += 1; else e_rej = 1;
         1: if (m_credit + 5 <= MAXC) m_credit += 5; else e_rej = 1;
         2: if (m_credit >= PRICE) begin
               e_vnd = 1;
               model_refund(m_credit - PRICE);
            end else e_dny = 1;
         default: if (m_credit > 0) model_refund(m_credit);
      endcase
   endtask

   initial begin
      vt[0]  = '{4'b0010, 5,  0, 0, 0, 0, 0};
      vt[1]  = '{4'b0001, 6,  0, 0, 0, 0, 0};
      vt[2]  = '{4'b0001, 7,  0, 0, 0, 0, 0};
      vt[3]  = '{4'b0010, 12, 0, 0, 0, 0, 0};
      vt[4]  = '{4'b0010, 12, 1, 0, 0, 0, 0};
      vt[5]  = '{4'b0100, 0,  0, 1, 0, 2, 0};
      vt[6]  = '{4'b0010, 5,  0, 0, 0, 0, 0};
      vt[7]  = '{4'b0001, 6,  0, 0, 0, 0, 0};
      vt[8]  = '{4'b0001, 7,  0, 0, 0, 0, 0};
      vt[9]  = '{4'b0100, 7,  0, 0, 1, 0, 0};
      vt[10] = '{4'b1000, 0,  0, 0, 0, GREEDY ? 2 : 7, GREEDY ? 1 : 0};
      vt[11] = '{4'b1000, 0,  0, 0, 0, 0, 0};
      vt[12] = '{4'b0010, 5,  0, 0, 0, 0, 0};
      vt[13] = '{4'b0010, 10, 0, 0, 0, 0, 0};
      vt[14] = '{4'b0010, 15, 0, 0, 0, 0, 0};
      vt[15] = '{4'b0001, 15, 1, 0, 0, 0, 0};
      vt[16] = '{4'b1000, 0,  0, 0, 0, GREEDY ? 0 : 15, GREEDY ? 3 : 0};

      // Reset state
      drive(4'b0000);
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      snap();
      check_state("reset", 0, 0, 0, 0, 0, 0);
      chk("reset_busy", int'(bus.busy), 0);

      // Input held high across reset release gives no edge
      bus.coin100 = 1'b1;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (6) @(negedge clk);
      chk("held_high_credit", int'(bus.credit), 0);
      chk("held_high_reject", cnt_rej - s_rej, 0);
      drive(4'b0000);
      repeat (3) @(negedge clk);

      for (int i = 0; i < 17; i++) begin
         snap();
         do_action(vt[i].act, 1);
         check_state($sformatf("vec%0d", i), vt[i].credit, vt[i].rej, vt[i].vnd,
                     vt[i].dny, vt[i].c1, vt[i].c5);
      end

      // Both coins in one cycle: 500 taken, 100 rejected
      snap();
      do_action(4'b0011, 1);
      check_state("both_coins", 5, 1, 0, 0, 0, 0);

      // Cancel beats coins in the same cycle
      snap();
      do_action(4'b1011, 1);
      check_state("cancel_coins", 0, 1, 0, 0, GREEDY ? 0 : 5, GREEDY ? 1 : 0);

      // Coin arriving with vend_req counts toward the vend
      do_action(4'b0010, 1);
      do_action(4'b0001, 1);
      do_action(4'b0001, 1);
      snap();
      do_action(4'b0110, 1);
      check_state("coin_with_vend", 0, 0, 1, 0, 2, 0);

      // Coin edge during CHANGE is rejected
      do_action(4'b0010, 1);
      do_action(4'b0010, 1);
      do_action(4'b0001, 1);
      do_action(4'b0001, 1);
      snap();
      @(negedge clk);
      drive(4'b1000);
      begin
         int k = 0;
         while (!bus.busy && k < 10) begin
            @(negedge clk);
            k++;
         end
      end
      chk("cancel_busy", int'(bus.busy), 1);
      drive(4'b0001);
      @(negedge clk);
      drive(4'b0000);
      settle();
      check_state("coin_in_change", 0, 1, 0, 0, GREEDY ? 2 : 12, GREEDY ? 2 : 0);

      // Reset mid-CHANGE abandons remaining change
      do_action(4'b0010, 1);
      do_action(4'b0010, 1);
      do_action(4'b0001, 1);
      do_action(4'b0001, 1);
      @(negedge clk);
      drive(4'b1000);
      begin
         int k = 0;
         while (!bus.busy && k < 10) begin
            @(negedge clk);
            k++;
         end
      end
      drive(4'b0000);
      @(negedge clk);
      chk("midchange_busy", int'(bus.busy), 1);
      #2 rst_n = 1'b0;
      #1;
      chk("async_reset_credit", int'(bus.credit), 0);
      chk("async_reset_busy", int'(bus.busy), 0);
      repeat (2) @(negedge clk);
      snap();
      rst_n = 1'b1;
      repeat (10) @(negedge clk);
      check_state("after_reset", 0, 0, 0, 0, 0, 0);

      // Random single actions against the transaction-level model
      m_credit = 0;
      for (int n = 0; n < 150; n++) begin
         int r, kind;
         logic [3:0] m;
         r = $urandom_range(0, 9);
         kind = (r <= 3) ? 0 : (r <= 6) ? 1 : (r <= 8) ? 2 : 3;
         m = 4'b0001 << kind;
         model_apply(kind);
         snap();
         do_action(m, $urandom_range(1, 3));
         check_state($sformatf("rnd%0d", n), m_credit, e_rej, e_vnd, e_dny, e_c1, e_c5);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
